// File: rtl/regfile_write_port.sv
// regfile_write_port: write side of the 32x64 register file.
// Buffers one write-back request in a staging entry, decodes its address to a
// one-hot enable and commits it into the register array one edge later. The
// flattened array is driven to the read-select muxes. X31 (XZR) reads zero.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   wr_valid  write request present
//   wr_ready  request accepted when wr_valid & wr_ready at a rising edge
//   wr_addr   destination register
//   wr_data   write data
//   wr_stall  holds the staged write uncommitted (pipeline freeze)
//   regs      register contents regs[i][b], to the read muxes
//   wr_done   one-cycle pulse after each commit edge
//   busy      staging entry occupied
//
// Build option: define REGFILE_BYPASS_EN to forward the staged write onto regs
// while it waits (write-through), even when stalled. ZERO_REG still reads 0.

module regfile_write_port #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         wr_stall,
  output logic [NREGS-1:0][WIDTH-1:0]  regs,
  output logic                         wr_done,
  output logic                         busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            stg_addr;
  logic [WIDTH-1:0]             stg_data;
  logic [NREGS-1:0][WIDTH-1:0]  mem;
  logic [NREGS-1:0]             en;
  logic                         accept;
  logic                         commit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (!wr_stall && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output / handshake decode; a stalled full entry blocks new requests
  always_comb begin
    wr_ready = 1'b0;
    commit   = 1'b0;
    busy     = 1'b0;
    case (state)
      EMPTY: wr_ready = !reset;
      FULL: begin
        busy     = 1'b1;
        commit   = !wr_stall;
        wr_ready = !reset && !wr_stall;
      end
      default: ;
    endcase
  end

  assign accept = wr_valid && wr_ready;

  // Staging entry: reloaded on every accept, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_addr <= '0;
      stg_data <= '0;
    end else if (accept) begin
      stg_addr <= wr_addr;
      stg_data <= wr_data;
    end
  end

  // One-hot write enable from the staged address
  always_comb begin
    en = '0;
    for (int i = 0; i < NREGS; i++) begin
      en[i] = commit && (stg_addr == ADDR_W'(i));
    end
  end

  // Register array; the zero register is never written
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        mem[i] <= '0;
      end else if (en[i] && (i != ZERO_REG)) begin
        mem[i] <= stg_data;
      end
    end
  end

  // Commit pulse, registered
  always_ff @(posedge clk) begin
    if (reset) wr_done <= 1'b0;
    else       wr_done <= commit;
  end

  // Read-side view of the array
  always_comb begin
    regs = mem;
`ifdef REGFILE_BYPASS_EN
    if (state == FULL) regs[stg_addr] = stg_data;
`else
`endif
    regs[ZERO_REG] = '0;
  end

endmodule
